// File: rtl/cosmos_solver_pkg.sv
// Shared types and constants for the BDD solver constraint sweep logic.
package cosmos_solver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_NEXT = 2'd2,
        ST_DONE = 2'd3
    } sweep_state_e;

    localparam int NUM_SPLITS_DEF = 8;

    // Fibonacci tap masks, bit (tap-1) set for each tap position.
    localparam logic [63:0] TAPS_W64 = 64'hD800_0000_0000_0000; // 64,63,61,60
    localparam logic [63:0] TAPS_W32 = 64'h0000_0000_8020_0003; // 32,22,2,1
    localparam logic [63:0] TAPS_W16 = 64'h0000_0000_0000_D008; // 16,15,13,4

    function automatic logic [63:0] lfsr_taps(input int width);
        case (width)
            64:      lfsr_taps = TAPS_W64;
            32:      lfsr_taps = TAPS_W32;
            16:      lfsr_taps = TAPS_W16;
            // Other widths get the two top bits only; not maximal length.
            default: lfsr_taps = 64'd3 << (width - 2);
        endcase
    endfunction

endpackage

// File: rtl/cand_lfsr.sv
// Candidate register: loads a seed (zero replaced by 1) or steps a Fibonacci LFSR.
module cand_lfsr
    import cosmos_solver_pkg::*;
#(
    parameter int CAND_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [CAND_W-1:0] seed_i,
    output logic [CAND_W-1:0] cand_o
);

    localparam logic [CAND_W-1:0] TAP_MASK = CAND_W'(lfsr_taps(CAND_W));
    localparam logic [CAND_W-1:0] ONE      = {{(CAND_W-1){1'b0}}, 1'b1};

    logic [CAND_W-1:0] cand_q;
    logic [CAND_W-1:0] cand_d;
    logic [CAND_W-1:0] step_val;

    // Next candidate: load has priority; a zero result is never produced.
    always_comb begin
        step_val = {cand_q[CAND_W-2:0], ^(cand_q & TAP_MASK)};
        if (step_val == '0) begin
            step_val = ONE;
        end
        cand_d = cand_q;
        if (load) begin
            cand_d = (seed_i == '0) ? ONE : seed_i;
        end else if (step) begin
            cand_d = step_val;
        end
    end

    // Candidate register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_q <= '0;
        end else begin
            cand_q <= cand_d;
        end
    end

    assign cand_o = cand_q;

endmodule

// File: rtl/constraint_sweep_ctrl.sv
// Sweeps split verdicts for one candidate, retries with LFSR candidates on failure,
// and reports sat/unsat plus try count over a valid/ready port.
//
// state   | meaning
// IDLE    | waiting for a solve request
// EVAL    | examining split verdict idx for the current candidate
// NEXT    | one-cycle bubble while the LFSR advances the candidate
// DONE    | result presented, waiting for res_ready
module constraint_sweep_ctrl
    import cosmos_solver_pkg::*;
#(
    parameter  int NUM_SPLITS = NUM_SPLITS_DEF,
    parameter  int CAND_W     = 64,
    parameter  int MAX_TRIES  = 255,
    localparam int SEL_W      = $clog2(NUM_SPLITS),
    localparam int TRY_W      = $clog2(MAX_TRIES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [CAND_W-1:0] seed_i,
    output logic [CAND_W-1:0] cand_o,
    output logic [SEL_W-1:0]  split_sel_o,
    input  logic              split_ok_i,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_sat,
    output logic [TRY_W-1:0]  res_tries
);

    localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NUM_SPLITS - 1);
    localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);

    sweep_state_e     state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic             res_sat_q, res_sat_d;
    logic             lfsr_load;
    logic             lfsr_step;

    cand_lfsr #(.CAND_W(CAND_W)) u_cand_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load   (lfsr_load),
        .step   (lfsr_step),
        .seed_i (seed_i),
        .cand_o (cand_o)
    );

    // State, split index, try counter and verdict registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            tries_q   <= '0;
            res_sat_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tries_q   <= tries_d;
            res_sat_q <= res_sat_d;
        end
    end

    // Next-state logic: early abort on the first failing split.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tries_d   = tries_q;
        res_sat_d = res_sat_q;
        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    idx_d     = '0;
                    tries_d   = '0;
                    res_sat_d = 1'b0;
                    state_d   = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (split_ok_i) begin
                    if (idx_q == LAST_IDX) begin
                        tries_d   = tries_q + TRY_W'(1);
                        res_sat_d = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        idx_d = idx_q + SEL_W'(1);
                    end
                end else begin
                    tries_d = tries_q + TRY_W'(1);
                    if (tries_d == TRY_LIMIT) begin
                        res_sat_d = 1'b0;
                        state_d   = ST_DONE;
                    end else begin
                        state_d = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                idx_d   = '0;
                state_d = ST_EVAL;
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs and candidate-register controls decoded from the current state.
    always_comb begin
        start_ready = (state_q == ST_IDLE);
        res_valid   = (state_q == ST_DONE);
        lfsr_load   = (state_q == ST_IDLE) && start_valid;
        lfsr_step   = (state_q == ST_NEXT);
        split_sel_o = idx_q;
        res_sat     = res_sat_q;
        res_tries   = tries_q;
    end

endmodule

// File: tb/tb_constraint_sweep_ctrl.sv
// Randomized bench for constraint_sweep_ctrl against a sweep-level reference model.
module tb_constraint_sweep_ctrl;

    localparam int NS   = 4;
    localparam int CW   = 64;
    localparam int MT   = 3;
    localparam int SW   = $clog2(NS);
    localparam int TW   = $clog2(MT + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_valid = 1'b0;
    logic          start_ready;
    logic [CW-1:0] seed_i = '0;
    logic [CW-1:0] cand_o;
    logic [SW-1:0] split_sel_o;
    logic          split_ok_i;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic          res_sat;
    logic [TW-1:0] res_tries;

    int            n_chk  = 0;
    int            n_pass = 0;
    int            zero_seen = 0;

    // verdict environment: 0 all pass, 1 split 2 fails on first candidate,
    // 2 split 0 always fails, 3 nibble-threshold pseudo-random verdicts
    int            mode = 0;
    logic [63:0]   first_cand = '0;
    int            thr = 0;

    constraint_sweep_ctrl #(.NUM_SPLITS(NS), .CAND_W(CW), .MAX_TRIES(MT)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .seed_i      (seed_i),
        .cand_o      (cand_o),
        .split_sel_o (split_sel_o),
        .split_ok_i  (split_ok_i),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_sat     (res_sat),
        .res_tries   (res_tries)
    );

    always #5 clk = ~clk;

    function automatic bit verdict(input logic [63:0] c, input int sel, input int m,
                                   input logic [63:0] fc, input int t);
        logic [63:0] nib;
        nib = (c >> (sel * 4)) & 64'hF;
        case (m)
            0:       return 1'b1;
            1:       return !(c == fc && sel == 2);
            2:       return sel != 0;
            default: return nib >= 64'(t);
        endcase
    endfunction

    always_comb split_ok_i = verdict(cand_o, int'(split_sel_o), mode, first_cand, thr);

    function automatic logic [63:0] lfsr_next(input logic [63:0] c);
        logic fb;
        fb = c[63] ^ c[62] ^ c[60] ^ c[59];
        return {c[62:0], fb};
    endfunction

    // Reference: walk candidates, count EVAL and NEXT cycles from the accept edge.
    function automatic void ref_solve(input logic [63:0] seed, output logic sat,
                                      output int tries, output logic [63:0] fin,
                                      output int cycles);
        logic [63:0] c;
        int k;
        c = (seed == 0) ? 64'd1 : seed;
        cycles = 0;
        sat = 1'b0;
        tries = 0;
        for (int t = 1; t <= MT; t++) begin
            k = NS;
            for (int s = NS - 1; s >= 0; s--)
                if (!verdict(c, s, mode, first_cand, thr)) k = s;
            tries = t;
            if (k == NS) begin
                cycles += NS;
                sat = 1'b1;
                break;
            end
            cycles += k + 1;
            if (t == MT) break;
            cycles += 1;
            c = lfsr_next(c);
        end
        fin = c;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic run_req(input logic [63:0] seed, input int m, input int t, input bit hold,
                           output logic exp_sat, output int exp_tries,
                           output logic [63:0] exp_cand);
        int exp_cyc;
        int cyc;
        bit seen;
        mode = m;
        thr = t;
        first_cand = seed;
        ref_solve(seed, exp_sat, exp_tries, exp_cand, exp_cyc);
        chk("start_ready_idle", start_ready, 1);
        seed_i = seed;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        chk("first_cand", cand_o, (seed == 0) ? 64'd1 : seed);
        cyc = 0;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (cand_o == 0) zero_seen++;
            @(posedge clk); #1;
            cyc++;
            if (res_valid) seen = 1;
        end
        chk("latency", cyc, exp_cyc);
        chk("res_sat", res_sat, exp_sat);
        chk("res_tries", res_tries, exp_tries);
        chk("cand_final", cand_o, exp_cand);
        if (!hold) begin
            res_ready = 1'b1;
            @(posedge clk); #1;
            res_ready = 1'b0;
            chk("res_valid_drop", res_valid, 0);
            chk("start_ready_back", start_ready, 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        s_sat;
        int          s_tries;
        logic [63:0] s_cand;
        logic [63:0] chain;
        logic [63:0] rseed;

        #3;
        chk("rst_start_ready", start_ready, 1);
        chk("rst_cand", cand_o, 0);
        chk("rst_sel", split_sel_o, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_sat", res_sat, 0);
        chk("rst_res_tries", res_tries, 0);
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;

        // all splits pass
        run_req(64'h1234, 0, 0, 0, s_sat, s_tries, s_cand);
        // retry once at split 2
        run_req(64'h1234, 1, 0, 0, s_sat, s_tries, s_cand);
        // exhaustion
        run_req(64'hABCD_0000_1234_5678, 2, 0, 0, s_sat, s_tries, s_cand);

        // zero seed, then chain requests for 1000 LFSR steps
        run_req(64'h0, 2, 0, 0, s_sat, s_tries, s_cand);
        chain = s_cand;
        for (int i = 0; i < 500; i++) begin
            run_req(chain, 2, 0, 0, s_sat, s_tries, s_cand);
            chain = s_cand;
        end
        chk("never_zero", zero_seen, 0);

        // random seeds and verdict densities
        for (int i = 0; i < 60; i++) begin
            rseed = {$urandom, $urandom};
            if ($urandom_range(0, 9) == 0) rseed = '0;
            run_req(rseed, 3, int'($urandom_range(0, 8)), 0, s_sat, s_tries, s_cand);
        end

        // backpressure: result held, start ignored
        run_req(64'h5555_AAAA_0F0F_F0F0, 1, 0, 1, s_sat, s_tries, s_cand);
        start_valid = 1'b1;
        seed_i = 64'hDEAD_BEEF;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", res_valid, 1);
            chk("bp_start_ready", start_ready, 0);
            chk("bp_sat", res_sat, s_sat);
            chk("bp_tries", res_tries, s_tries);
            chk("bp_cand", cand_o, s_cand);
        end
        start_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("bp_release_valid", res_valid, 0);
        chk("bp_release_ready", start_ready, 1);
        @(posedge clk); #1;
        chk("bp_no_accept", start_ready, 1);

        // reset mid-sweep
        mode = 0;
        seed_i = 64'h7777;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_start_ready", start_ready, 1);
        chk("mid_rst_cand", cand_o, 0);
        chk("mid_rst_sel", split_sel_o, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_res_sat", res_sat, 0);
        chk("mid_rst_res_tries", res_tries, 0);
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_no_result", res_valid, 0);
        run_req(64'h1234, 1, 0, 0, s_sat, s_tries, s_cand);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/constraint_sweep_ctrl.md
# constraint_sweep_ctrl

Sequencer for the constraint split bank of the BDD solver. It drives one candidate assignment vector to all split modules and reads the split verdicts back one per cycle through a shared select/verdict pair. On the first failing split it replaces the candidate with the next LFSR value and re-sweeps, up to a bounded number of tries. It then reports satisfied/unsatisfied and the try count over a valid/ready result port.

## Interface
- `NUM_SPLITS`, 8: number of constraint split outputs swept; ≥2.
- `CAND_W`, 64: candidate vector width, i.e. concatenated solver variables.
- `MAX_TRIES`, 255: maximum candidates evaluated per request; ≥1.
- `SEL_W`, `$clog2(NUM_SPLITS)`: derived; select width.
- `TRY_W`, `$clog2(MAX_TRIES+1)`: derived; try-count width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start_valid` in 1: solve request.
- `start_ready` out 1: controller idle, can accept a request.
- `seed_i` in CAND_W: first candidate, sampled on request accept.
- `cand_o` out CAND_W: candidate fed to every split module.
- `split_sel_o` out SEL_W: index of the split verdict being examined.
- `split_ok_i` in 1: verdict of the selected split; combinational from `cand_o`/`split_sel_o`.
- `res_valid` out 1: result available.
- `res_ready` in 1: result consumed.
- `res_sat` out 1: 1 = `cand_o` satisfies all splits.
- `res_tries` out TRY_W: candidates evaluated, 1..MAX_TRIES.

## Operation
States: IDLE, EVAL, NEXT, DONE.
- **IDLE**
  - `start_ready`=1.
  - On `start_valid`: latch `seed_i` into the candidate register; an all-zero seed is replaced by 1.
  - Clear idx and tries, then go to EVAL.
- **EVAL**
  - `split_sel_o`=idx; `split_ok_i` is sampled at the clock edge.
  - ok and idx==NUM_SPLITS-1: tries+=1, `res_sat`=1, go to DONE.
  - ok, otherwise: idx+=1, stay in EVAL.
  - fail: tries+=1. If the new tries==MAX_TRIES, `res_sat`=0 and go to DONE; otherwise go to NEXT.
  - Early abort on the first failing split; later splits are not examined.
- **NEXT**
  - Advance the LFSR one step; the candidate takes the new value.
  - idx=0, go to EVAL. This is a one-cycle bubble.
- **DONE**
  - `res_valid`=1; `res_sat`, `res_tries` and `cand_o` are held stable.
  - On `res_ready`, go to IDLE.
  - `res_ready` while `res_valid`=0 is ignored.
- **LFSR**
  - Fibonacci, maximal length.
  - CAND_W=64 taps: 64,63,61,60.
  - The next value is never zero.
  - The candidate register changes only in IDLE-accept and NEXT.
- `start_valid` outside IDLE is ignored; `start_ready`=0 there.

## Timing
- Reset values:
  - state IDLE, `start_ready`=1.
  - `cand_o`=0, `split_sel_o`=0.
  - `res_valid`=0, `res_sat`=0, `res_tries`=0.
  - idx, tries and the LFSR register all 0.
- Reset asserted mid-solve: immediate return to the reset values; no result is emitted.
- Latency, with the accept edge at T:
  - EVAL occupies cycles T+1 onward.
  - All splits pass on the first candidate: `res_valid` is high from T+NUM_SPLITS+1.
  - A candidate failing at index k costs k+1 EVAL cycles plus 1 NEXT cycle.
- Result handshake:
  - Transfer occurs on a cycle with `res_valid`&`res_ready`.
  - `start_ready` returns the following cycle.
  - There is no same-cycle result-to-start overlap.
- `cand_o` is stable throughout each sweep; `split_ok_i` must settle within one cycle.

## Structure
- Shared package `cosmos_solver_pkg`:
  - state enum.
  - LFSR tap-mask constants per CAND_W (64, 32, 16).
  - `NUM_SPLITS` default.
- Sub-module `cand_lfsr` contains:
  - the candidate register;
  - the load (with zero-seed substitution) and step controls.
- The controller FSM, idx counter and tries counter stay in `constraint_sweep_ctrl`.
- Split modules are instantiated outside the block.
- The verdict mux `split_ok_i` is built outside the block from `split_sel_o`.

## Test plan
- **All pass**: NUM_SPLITS=4, verdict always 1, seed 0x1234.
  - `res_valid` at T+5.
  - `res_sat`=1, `res_tries`=1, `cand_o`=0x1234.
- **Retry**: verdict 0 at split 2 for the first candidate only.
  - Second candidate = LFSR(0x1234).
  - `res_tries`=2, `res_sat`=1.
  - `res_valid` at T+1+3+1+4.
- **Exhaustion**: MAX_TRIES=3, split 0 always fails.
  - `res_sat`=0, `res_tries`=3.
  - Exactly 3 EVAL and 2 NEXT cycles.
- **Zero seed**: `seed_i`=0 gives `cand_o`=1 in the first EVAL.
  - Over 1000 NEXT steps `cand_o` is never 0.
- **Backpressure and reset**:
  - `res_ready` held low for 10 cycles: outputs stay stable, `start_valid` is ignored.
  - `rst` pulsed during EVAL: all outputs return to reset values within the same cycle, then a new request is accepted.
